// File: rtl/step_ctrl.sv
// Step controller for the Core: debounced single/burst stepping and free-run with a PC
// breakpoint that halts before the breakpoint instruction executes.
module step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DB_W            = 20,
    parameter int unsigned BURST_W         = 8
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               step_btn,
    input  logic               run_en,
    input  logic [BURST_W-1:0] burst_n,
    input  logic               bp_en,
    input  logic [31:0]        bp_addr,
    input  logic [31:0]        pc,
    output logic               step,
    output logic               halted,
    output logic               bp_hit,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StRun   = 2'd2,
        StBreak = 2'd3
    } state_e;

    logic               btn_meta_q;
    logic               btn_sync_q;
    logic               btn_db_q;
    logic               btn_db_prev_q;
    logic [DB_W-1:0]    db_cnt_q;
    logic               press;

    state_e             state_q, state_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic               bp_hit_q, bp_hit_d;
    logic               bp_match;
    logic [BURST_W-1:0] burst_load;

    // Button path: two-flop synchronizer, then a level must hold for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            btn_meta_q    <= 1'b0;
            btn_sync_q    <= 1'b0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            db_cnt_q      <= '0;
        end else begin
            btn_meta_q    <= step_btn;
            btn_sync_q    <= btn_meta_q;
            btn_db_prev_q <= btn_db_q;
            if (btn_sync_q == btn_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_q <= btn_sync_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign press      = btn_db_q && !btn_db_prev_q;
    assign bp_match   = bp_en && (pc == bp_addr);
    assign burst_load = (burst_n == '0) ? BURST_W'(1) : burst_n;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            bp_hit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bp_hit_q    <= bp_hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bp_hit_d    = bp_hit_q;
        unique case (state_q)
            StIdle: begin
                if (run_en) begin
                    state_d = StRun;
                end else if (press) begin
                    state_d     = StBurst;
                    remaining_d = burst_load;
                end
            end
            StBurst: begin
                remaining_d = remaining_q - BURST_W'(1);
                if (remaining_q == BURST_W'(1)) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (!run_en) begin
                    state_d = StIdle;
                end else if (bp_match) begin
                    state_d  = StBreak;
                    bp_hit_d = 1'b1;
                end
            end
            StBreak: begin
                // Dropping run_en wins over a simultaneous press.
                if (!run_en) begin
                    state_d  = StIdle;
                    bp_hit_d = 1'b0;
                end else if (press) begin
                    state_d     = StBurst;
                    bp_hit_d    = 1'b0;
                    remaining_d = burst_load;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Step drops in the very cycle pc hits the breakpoint, so that instruction never runs.
    assign step   = (state_q == StBurst) || ((state_q == StRun) && !bp_match);
    assign halted = (state_q == StIdle) || (state_q == StBreak);
    assign bp_hit = bp_hit_q;
    assign state  = state_q;

endmodule
